// File: rtl/dp_ctrl_pkg.sv
// Shared datapath-control types for the SMAC input distributor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dp_ctrl_pkg;

    // Number of SMAC groups fed by the distributor.
    localparam int N_SMAC_GROUPS = 4;

    // Index of one SMAC group.
    typedef logic [1:0] smac_grp_t;

    // Sequencer states of the input distributor.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } dp_demux_state_t;

endpackage

// File: rtl/dp_demux_cnt.sv
// Word-position / group-index counter pair for the SMAC input distributor.
// Latency: counters update on the edge that sees clr or inc; the wrap flags are combinational.
// Backpressure: none; inc is qualified by the caller with the accepted-beat condition.
//
// Ports: clk, rst (async, active high); clr restarts at group 0 / word 0;
// inc advances one word; hold_grp keeps act_wb at 0 (broadcast);
// word_idx, act_wb are the counters; word_wrap / grp_wrap flag the last word of a
// group and the last group.
module dp_demux_cnt
    import dp_ctrl_pkg::*;
#(
    parameter int WORDS_PER_GROUP = 4,
    parameter int IDX_W           = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold_grp,
    output logic [IDX_W-1:0] word_idx,
    output smac_grp_t        act_wb,
    output logic             word_wrap,
    output logic             grp_wrap
);

    assign word_wrap = (word_idx == IDX_W'(WORDS_PER_GROUP - 1));
    assign grp_wrap  = (act_wb == smac_grp_t'(N_SMAC_GROUPS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            act_wb   <= '0;
        end else if (clr) begin
            word_idx <= '0;
            act_wb   <= '0;
        end else if (inc) begin
            if (word_wrap) begin
                word_idx <= '0;
                // Group index rolls 3 -> 0 on its own after the final beat.
                if (!hold_grp) begin
                    act_wb <= act_wb + 2'd1;
                end
            end else begin
                word_idx <= word_idx + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/dp_demux_seq.sv
// Scatters a valid/ready word stream into the four SMAC groups (group 1..4, WORDS_PER_GROUP words each).
// Latency: a beat accepted at edge n shows on its out_to_SMACs bus and load_en in cycle n+1.
// Backpressure: in_ready is registered and high exactly while in LOAD; it never looks at in_valid.
//
// Ports: clk, rst (async, active high); start begins a sequence from IDLE;
// in_data/in_valid/in_ready input handshake; out_to_SMACs1..4 registered per-group
// word buses that hold between loads; load_en one-hot new-word strobe per group;
// act_wb / word_idx current group and word position; busy high in LOAD;
// done one-cycle completion pulse.
// Optional feature macro DP_DEMUX_BCAST_EN: adds the bcast input; start with bcast=1
// writes every beat to all four groups and ends after WORDS_PER_GROUP beats.
module dp_demux_seq
    import dp_ctrl_pkg::*;
#(
    parameter int  BW              = 128,
    parameter int  WORDS_PER_GROUP = 4,
    localparam int IDX_W           = (WORDS_PER_GROUP > 1) ? $clog2(WORDS_PER_GROUP) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
`ifdef DP_DEMUX_BCAST_EN
    input  logic             bcast,
`endif
    input  logic [BW-1:0]    in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [BW-1:0]    out_to_SMACs1,
    output logic [BW-1:0]    out_to_SMACs2,
    output logic [BW-1:0]    out_to_SMACs3,
    output logic [BW-1:0]    out_to_SMACs4,
    output logic [3:0]       load_en,
    output logic [1:0]       act_wb,
    output logic [IDX_W-1:0] word_idx,
    output logic             busy,
    output logic             done
);

    dp_demux_state_t state;

    logic      seq_start;
    logic      accept;
    logic      last_beat;
    logic      word_wrap;
    logic      grp_wrap;
    logic      bcast_mode;
    smac_grp_t grp_cur;
    logic [N_SMAC_GROUPS-1:0] grp_hit;
    logic [BW-1:0]            grp_q [N_SMAC_GROUPS];

    assign seq_start = (state == IDLE) && start;
    assign accept    = in_valid && in_ready;
    // Broadcast sequences finish after one group's worth of beats.
    assign last_beat = accept && word_wrap && (bcast_mode || grp_wrap);

`ifdef DP_DEMUX_BCAST_EN
    // Mode is captured with start and frozen for the whole sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_mode <= 1'b0;
        end else if (seq_start) begin
            bcast_mode <= bcast;
        end
    end
`else
    assign bcast_mode = 1'b0;
`endif

    dp_demux_cnt #(
        .WORDS_PER_GROUP (WORDS_PER_GROUP),
        .IDX_W           (IDX_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .clr       (seq_start),
        .inc       (accept),
        .hold_grp  (bcast_mode),
        .word_idx  (word_idx),
        .act_wb    (grp_cur),
        .word_wrap (word_wrap),
        .grp_wrap  (grp_wrap)
    );

    assign act_wb = grp_cur;

    // Sequencer with registered handshake/status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            in_ready <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= LOAD;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                LOAD: begin
                    if (last_beat) begin
                        state    <= DONE;
                        in_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                end
            endcase
        end
    end

    // Which group buses take this beat.
    always_comb begin
        grp_hit = '0;
        if (accept) begin
            if (bcast_mode) begin
                grp_hit = '1;
            end else begin
                grp_hit[grp_cur] = 1'b1;
            end
        end
    end

    // Word registers hold their last load; load_en is a one-cycle strobe per beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int g = 0; g < N_SMAC_GROUPS; g++) begin
                grp_q[g] <= '0;
            end
            load_en <= '0;
        end else begin
            for (int g = 0; g < N_SMAC_GROUPS; g++) begin
                if (grp_hit[g]) begin
                    grp_q[g] <= in_data;
                end
            end
            load_en <= grp_hit;
        end
    end

    assign out_to_SMACs1 = grp_q[0];
    assign out_to_SMACs2 = grp_q[1];
    assign out_to_SMACs3 = grp_q[2];
    assign out_to_SMACs4 = grp_q[3];

endmodule

// File: tb/tb_dp_demux_seq.sv
// Self-checking bench for the SMAC input distributor (scatter order, hold, reset abort).
// Latency: expects bus/load_en updates one cycle after each accepted beat.
// Backpressure: drives in_valid patterns (solid, alternating, random) against in_ready.
module tb_dp_demux_seq;

    localparam int BW      = 128;
    localparam int W       = 4;
    localparam int NB      = 4 * W;
    localparam int CYC_MAX = 200;

    logic          clk;
    logic          rst;
    logic          start;
`ifdef DP_DEMUX_BCAST_EN
    logic          bcast;
`endif
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] b1, b2, b3, b4;
    logic [3:0]    load_en;
    logic [1:0]    act_wb;
    logic [1:0]    word_idx;
    logic          busy;
    logic          done;

    int total = 0;
    int bad   = 0;

    // Reference model of the four bus contents.
    logic [BW-1:0] mbus [4];

    dp_demux_seq #(
        .BW              (BW),
        .WORDS_PER_GROUP (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
`ifdef DP_DEMUX_BCAST_EN
        .bcast         (bcast),
`endif
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_to_SMACs1 (b1),
        .out_to_SMACs2 (b2),
        .out_to_SMACs3 (b3),
        .out_to_SMACs4 (b4),
        .load_en       (load_en),
        .act_wb        (act_wb),
        .word_idx      (word_idx),
        .busy          (busy),
        .done          (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [BW-1:0] bus(input int g);
        case (g)
            0:       return b1;
            1:       return b2;
            2:       return b3;
            default: return b4;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_buses(input string tag);
        for (int g = 0; g < 4; g++) check(tag, bus(g), mbus[g]);
    endtask

    // mode 0: solid valid, data k; 1: valid every other cycle, data k;
    // 2: random valid and data; 3: solid valid with a stray start mid-LOAD.
    task automatic run_seq(input int mode);
        logic [BW-1:0] d [NB];
        logic [3:0]    exp_le;
        logic          v;
        int            k;
        int            cyc;
        for (int i = 0; i < NB; i++)
            d[i] = (mode == 2) ? {$urandom, $urandom, $urandom, $urandom} : BW'(i);
        start = 1'b1;
        step();
        start = 1'b0;
        check("ld_ready", 128'(in_ready), 128'(1));
        check("ld_busy", 128'(busy), 128'(1));
        check("ld_act", 128'(act_wb), 128'(0));
        check("ld_idx", 128'(word_idx), 128'(0));
        k   = 0;
        cyc = 0;
        while (k < NB && cyc < CYC_MAX) begin
            v = (mode == 1) ? (cyc % 2 == 1) :
                (mode == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
            start    = (mode == 3 && cyc == 5);
            in_valid = v;
            in_data  = v ? d[k] : {$urandom, $urandom, $urandom, $urandom};
            exp_le   = '0;
            if (v) begin
                exp_le[k / W] = 1'b1;
                mbus[k / W]   = d[k];
                k++;
            end
            step();
            cyc++;
            check("load_en", 128'(load_en), 128'(exp_le));
            check_buses("bus");
            if (k < NB) begin
                check("ready", 128'(in_ready), 128'(1));
                check("no_done", 128'(done), 128'(0));
                check("act_wb", 128'(act_wb), 128'(k / W));
                check("word_idx", 128'(word_idx), 128'(k % W));
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (k < NB) check("timeout_beats", 128'(k), 128'(NB));
        check("done_pulse", 128'(done), 128'(1));
        check("done_busy", 128'(busy), 128'(0));
        check("done_ready", 128'(in_ready), 128'(0));
        check("done_act", 128'(act_wb), 128'(0));
        check("done_idx", 128'(word_idx), 128'(0));
        step();
        check("done_drop", 128'(done), 128'(0));
        check("idle_le", 128'(load_en), 128'(0));
        check("idle_busy", 128'(busy), 128'(0));
        for (int g = 0; g < 4; g++) check("final_bus", bus(g), d[g * W + W - 1]);
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
`ifdef DP_DEMUX_BCAST_EN
        bcast    = 1'b0;
`endif
        for (int g = 0; g < 4; g++) mbus[g] = '0;
        step();
        step();
        // Reset state
        check("rst_ready", 128'(in_ready), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_le", 128'(load_en), 128'(0));
        check("rst_act", 128'(act_wb), 128'(0));
        check("rst_idx", 128'(word_idx), 128'(0));
        check_buses("rst_bus");
        rst = 1'b0;
        step();
        check("idle_ready", 128'(in_ready), 128'(0));

        // Solid stream 0..15
        run_seq(0);
        // Alternating valid: same final contents
        run_seq(1);

        // in_valid held in IDLE: not accepted, buses hold
        in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_data = {$urandom, $urandom, $urandom, $urandom};
            step();
            check("idle_noready", 128'(in_ready), 128'(0));
            check("idle_noload", 128'(load_en), 128'(0));
            check("idle_nobusy", 128'(busy), 128'(0));
            check_buses("idle_hold");
        end
        in_valid = 1'b0;

        // Stray start during LOAD is ignored
        run_seq(3);
        // Back-to-back: start in the first IDLE cycle
        run_seq(2);
        run_seq(2);

        // Reset after 6 beats aborts the sequence
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            mbus[i / W] = in_data;
            step();
        end
        in_valid = 1'b0;
        check_buses("pre_abort_bus");
        rst = 1'b1;
        #1;
        for (int g = 0; g < 4; g++) mbus[g] = '0;
        check("abort_ready", 128'(in_ready), 128'(0));
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_le", 128'(load_en), 128'(0));
        check("abort_act", 128'(act_wb), 128'(0));
        check("abort_idx", 128'(word_idx), 128'(0));
        check_buses("abort_bus");
        step();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_abort_done", 128'(done), 128'(0));
            check("post_abort_busy", 128'(busy), 128'(0));
        end
        run_seq(0);

`ifdef DP_DEMUX_BCAST_EN
        // Broadcast: W beats to all groups
        bcast = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        bcast = 1'b0;
        for (int i = 0; i < W; i++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom, $urandom, $urandom};
            for (int g = 0; g < 4; g++) mbus[g] = in_data;
            step();
            check("bc_le", 128'(load_en), 128'(4'b1111));
            check_buses("bc_bus");
            check("bc_act", 128'(act_wb), 128'(0));
            check("bc_done", 128'(done), 128'(i == W - 1));
        end
        in_valid = 1'b0;
        check("bc_busy", 128'(busy), 128'(0));
        step();
        check("bc_done_drop", 128'(done), 128'(0));
        run_seq(0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
